// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection: DM wins unless it has used up its burst while IF waits.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DM_BURST = 3,
    parameter int unsigned SW           = 2
) (
    input  logic          if_req_i,
    input  logic          dm_req_i,
    input  logic [SW-1:0] dm_streak_i,
    output logic          pick_valid_c_o,
    output logic          pick_owner_c_o
);

    always_comb begin
        pick_valid_c_o = if_req_i | dm_req_i;
        pick_owner_c_o = OWNER_IF;
        if (dm_req_i && (!if_req_i || (dm_streak_i < SW'(MAX_DM_BURST)))) begin
            pick_owner_c_o = OWNER_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory stage.
// Optional busy timeout with error completion enabled by ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_DM_BURST = 3,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_DONE,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    output logic          DM_GNT,
    output logic          DM_DONE,
    output logic [DW-1:0] RDATA,
    output logic          ERR,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    output logic          MUX_SEL
);

    localparam int unsigned SW = $clog2(MAX_DM_BURST + 1);

    arb_state_e    state_q;
    logic [SW-1:0] dm_streak_q;
    logic          if_gnt_q, dm_gnt_q, if_done_q, dm_done_q;
    logic          mem_en_q, mem_we_q, mux_sel_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, rdata_q;
    logic          pick_valid_c, pick_owner_c;

    mem_arb_pick #(
        .MAX_DM_BURST (MAX_DM_BURST),
        .SW           (SW)
    ) u_pick (
        .if_req_i       (IF_REQ),
        .dm_req_i       (DM_REQ),
        .dm_streak_i    (dm_streak_q),
        .pick_valid_c_o (pick_valid_c),
        .pick_owner_c_o (pick_owner_c)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // Arbitration FSM with all outputs held in registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            dm_streak_q <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mux_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_c) begin
                        state_q   <= BUSY;
                        mem_en_q  <= 1'b1;
                        mux_sel_q <= pick_owner_c;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        if (pick_owner_c == OWNER_DM) begin
                            dm_gnt_q    <= 1'b1;
                            mem_addr_q  <= DM_ADDR;
                            mem_wdata_q <= DM_WDATA;
                            mem_we_q    <= DM_WE;
                            if (dm_streak_q != SW'(MAX_DM_BURST)) begin
                                dm_streak_q <= dm_streak_q + SW'(1);
                            end
                        end else begin
                            if_gnt_q    <= 1'b1;
                            mem_addr_q  <= IF_ADDR;
                            mem_wdata_q <= '0;
                            mem_we_q    <= 1'b0;
                            dm_streak_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if_gnt_q <= 1'b0;
                    dm_gnt_q <= 1'b0;
                    if (MEM_ACK) begin
                        state_q  <= RESP;
                        mem_en_q <= 1'b0;
                        rdata_q  <= mem_we_q ? '0 : MEM_RDATA;
                        if (mux_sel_q == OWNER_DM) dm_done_q <= 1'b1;
                        else                       if_done_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        err_q    <= 1'b0;
                    end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
                        state_q  <= RESP;
                        mem_en_q <= 1'b0;
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                        if (mux_sel_q == OWNER_DM) dm_done_q <= 1'b1;
                        else                       if_done_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
                    end
                end
                RESP: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IF_GNT    = if_gnt_q;
    assign DM_GNT    = dm_gnt_q;
    assign IF_DONE   = if_done_q;
    assign DM_DONE   = dm_done_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_WE    = mem_we_q;
    assign MUX_SEL   = mux_sel_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned MAXB = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ, DM_REQ, DM_WE, MEM_ACK;
    logic [31:0] IF_ADDR, DM_ADDR, DM_WDATA, MEM_RDATA;
    logic        IF_GNT, IF_DONE, DM_GNT, DM_DONE, ERR, MEM_EN, MEM_WE, MUX_SEL;
    logic [31:0] RDATA, MEM_ADDR, MEM_WDATA;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_BURST(MAXB), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_DONE(IF_DONE),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_GNT(DM_GNT), .DM_DONE(DM_DONE), .RDATA(RDATA), .ERR(ERR),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MUX_SEL(MUX_SEL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({IF_GNT, DM_GNT, IF_DONE, DM_DONE, MEM_EN}), 32'd0);
    endtask

    // Reference model state: streak of DM grants and the expected latched transaction
    int          m_streak;
    logic        m_owner;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we;

    task automatic model_pick(input logic ifr, input logic dmr);
        if (dmr && (!ifr || m_streak < int'(MAXB))) begin
            m_owner  = 1'b1;
            m_addr   = DM_ADDR;
            m_wdata  = DM_WDATA;
            m_we     = DM_WE;
            m_streak = (m_streak + 1 > int'(MAXB)) ? int'(MAXB) : m_streak + 1;
        end else begin
            m_owner  = 1'b0;
            m_addr   = IF_ADDR;
            m_wdata  = 32'd0;
            m_we     = 1'b0;
            m_streak = 0;
        end
    endtask

    task automatic chk_grant(input string tag);
        chk1({tag, "_if_gnt"}, IF_GNT, !m_owner);
        chk1({tag, "_dm_gnt"}, DM_GNT, m_owner);
        chk1({tag, "_mux"}, MUX_SEL, m_owner);
        chk({tag, "_addr"}, MEM_ADDR, m_addr);
        chk({tag, "_wdata"}, MEM_WDATA, m_wdata);
        chk1({tag, "_we"}, MEM_WE, m_we);
        chk1({tag, "_en"}, MEM_EN, 1'b1);
    endtask

    initial begin
        logic owners [5];
        int   n;
        owners = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        RST = 1'b1; IF_REQ = 0; DM_REQ = 0; DM_WE = 0; MEM_ACK = 0;
        IF_ADDR = '0; DM_ADDR = '0; DM_WDATA = '0; MEM_RDATA = '0;
        #1;
        chk("rst_ctrl", 32'({IF_GNT, DM_GNT, IF_DONE, DM_DONE, MEM_EN, MEM_WE, MUX_SEL, ERR}), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_addr", MEM_ADDR, 32'd0);
        step(); step();
        RST = 1'b0;
        step();
        m_streak = 0;

        // Fetch read with ack in the second busy cycle
        IF_REQ = 1; IF_ADDR = 32'h40;
        model_pick(1'b1, 1'b0);
        step();
        chk_grant("if_rd");
        step();
        chk1("if_rd_gnt_pulse", IF_GNT, 1'b0);
        chk1("if_rd_busy_en", MEM_EN, 1'b1);
        chk1("if_rd_no_done", IF_DONE, 1'b0);
        MEM_ACK = 1; MEM_RDATA = 32'hDEADBEEF;
        step();
        chk1("if_rd_done", IF_DONE, 1'b1);
        chk("if_rd_rdata", RDATA, 32'hDEADBEEF);
        chk1("if_rd_err", ERR, 1'b0);
        chk1("if_rd_en_off", MEM_EN, 1'b0);
        IF_REQ = 0; MEM_ACK = 0;
        step();
        chk_quiet("if_rd_idle");
        chk("if_rd_rdata_hold", RDATA, 32'hDEADBEEF);

        // Data write: latched fields must not follow input changes during BUSY
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 32'h100; DM_WDATA = 32'h12345678;
        model_pick(1'b0, 1'b1);
        step();
        chk_grant("dm_wr");
        DM_ADDR = 32'h999; DM_WDATA = 32'hCAFEF00D; DM_WE = 0;
        step();
        chk_grant_hold: begin
            chk("dm_wr_wdata_stable", MEM_WDATA, 32'h12345678);
            chk("dm_wr_addr_stable", MEM_ADDR, 32'h100);
            chk1("dm_wr_we_stable", MEM_WE, 1'b1);
        end
        MEM_ACK = 1; MEM_RDATA = 32'hFFFFFFFF;
        step();
        chk1("dm_wr_done", DM_DONE, 1'b1);
        chk1("dm_wr_if_done", IF_DONE, 1'b0);
        chk("dm_wr_rdata", RDATA, 32'd0);
        DM_REQ = 0; MEM_ACK = 0;
        step();
        chk_quiet("dm_wr_idle");

        // Spurious ack with no request
        MEM_ACK = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet("spurious_ack");
        end
        MEM_ACK = 0;

        // Reset in the middle of a DM write
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 32'h200; DM_WDATA = 32'hA5A5A5A5;
        step();
        chk1("rst_mid_gnt", DM_GNT, 1'b1);
        RST = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({IF_GNT, DM_GNT, IF_DONE, DM_DONE, MEM_EN, MEM_WE, MUX_SEL, ERR}), 32'd0);
        chk("rst_mid_addr", MEM_ADDR, 32'd0);
        chk("rst_mid_wdata", MEM_WDATA, 32'd0);
        chk("rst_mid_rdata", RDATA, 32'd0);
        #2;
        RST = 1'b0;
        m_streak = 0;
        DM_REQ = 0; DM_WE = 0; IF_REQ = 1; IF_ADDR = 32'h80;
        model_pick(1'b1, 1'b0);
        step();
        chk_grant("post_rst");
        chk1("post_rst_no_done", DM_DONE, 1'b0);
        MEM_ACK = 1; MEM_RDATA = 32'h0BADF00D;
        step();
        chk1("post_rst_done", IF_DONE, 1'b1);
        IF_REQ = 0; MEM_ACK = 0;
        step();

        // Both requesting continuously with immediate ack: burst limit lets IF in
        IF_REQ = 1; DM_REQ = 1; DM_WE = 0; MEM_ACK = 1;
        IF_ADDR = 32'h1000; DM_ADDR = 32'h2000; MEM_RDATA = 32'h55;
        for (int t = 0; t < 5; t++) begin
            step();
            chk1("prio_dm_gnt", DM_GNT, owners[t]);
            chk1("prio_if_gnt", IF_GNT, !owners[t]);
            step();
            chk1("prio_dm_done", DM_DONE, owners[t]);
            chk1("prio_if_done", IF_DONE, !owners[t]);
            if (t == 4) begin
                IF_REQ = 0; DM_REQ = 0;
            end
            step();
            chk_quiet("prio_idle");
        end
        MEM_ACK = 0;
        m_streak = 1;

        // Randomized transactions against the model
        for (int it = 0; it < 150; it++) begin
            logic ifr, dmr;
            int   dly;
            ifr = ($urandom_range(3) != 0);
            dmr = ($urandom_range(3) != 0);
            IF_REQ = ifr; DM_REQ = dmr;
            IF_ADDR = $urandom; DM_ADDR = $urandom; DM_WDATA = $urandom; DM_WE = 1'($urandom);
            MEM_ACK = 1'($urandom);
            if (!ifr && !dmr) begin
                step();
                chk_quiet("rnd_noreq");
                continue;
            end
            MEM_ACK = 0;
            model_pick(ifr, dmr);
            step();
            chk_grant("rnd_gnt");
            dly = $urandom_range(3);
            for (int d = 0; d < dly; d++) begin
                IF_REQ = 1'($urandom); DM_REQ = 1'($urandom);
                DM_ADDR = $urandom; DM_WDATA = $urandom; IF_ADDR = $urandom; DM_WE = 1'($urandom);
                step();
                chk1("rnd_busy_en", MEM_EN, 1'b1);
                chk("rnd_busy_addr", MEM_ADDR, m_addr);
                chk("rnd_busy_wdata", MEM_WDATA, m_wdata);
                chk("rnd_busy_nodone", 32'({IF_DONE, DM_DONE, IF_GNT, DM_GNT}), 32'd0);
            end
            MEM_ACK = 1; m_rdata = $urandom; MEM_RDATA = m_rdata;
            step();
            chk1("rnd_if_done", IF_DONE, !m_owner);
            chk1("rnd_dm_done", DM_DONE, m_owner);
            chk("rnd_rdata", RDATA, m_we ? 32'd0 : m_rdata);
            chk1("rnd_err", ERR, 1'b0);
            chk1("rnd_resp_en", MEM_EN, 1'b0);
            IF_REQ = 0; DM_REQ = 0; MEM_ACK = 1'($urandom);
            step();
            chk_quiet("rnd_idle");
        end
        MEM_ACK = 0;

`ifdef ARB_TIMEOUT_EN
        // No ack at all: error completion 16 cycles after the grant
        IF_REQ = 1; IF_ADDR = 32'h300; MEM_RDATA = 32'h77777777;
        step();
        chk1("tmo_gnt", IF_GNT, 1'b1);
        IF_REQ = 0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (IF_DONE) begin
                n = k;
                break;
            end
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk1("tmo_err", ERR, 1'b1);
        chk("tmo_rdata", RDATA, 32'd0);
        step();
        chk_quiet("tmo_idle");
`else
        n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
